ofdm_adc_capture: RTL and testbench
===================================

OFDM_ADC_CAPTURE -- requirements
Module: ofdm_adc_capture

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 64, samples per packet (legal range 2..1024).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries (power of 2, >=4).
REQ-003 SHALL have port sample_clock_adc, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset_reset, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port capture_enable, input, 1, arms frame capture.
REQ-006 SHALL have port ADC_Capture_ChA_Data, input, 14, real sample (two's complement).
REQ-007 SHALL have port ADC_Capture_ChB_Data, input, 14, imaginary sample (two's complement).
REQ-008 SHALL have port aso_out0_data, output, 34, {real[33:20], imag[19:6], BFP exponent[5:0]}.
REQ-009 SHALL have port aso_out0_valid, output, 1, Avalon-ST source valid.
REQ-010 SHALL have port aso_out0_ready, input, 1, Avalon-ST sink ready.
REQ-011 SHALL have port aso_out0_startofpacket, output, 1, first word of frame.
REQ-012 SHALL have port aso_out0_endofpacket, output, 1, last word of frame.
REQ-013 SHALL have port overflow, output, 1, sticky FIFO-overflow flag.
REQ-014 SHALL have port clear_overflow, input, 1, clears overflow.
REQ-015 SHALL have port frame_count, output, 16, completed-frame counter, wraps 65535->0.

Function
REQ-016 SHALL register both ADC inputs every cycle into an input stage (stage 1); writes use stage-1 values.
REQ-017 SHALL form each word as {ChA, ChB, 6'b000000}; exponent field always 0.
REQ-018 SHALL buffer words plus sop/eop bits in a show-ahead FIFO of FIFO_DEPTH; aso_out0_valid = FIFO not empty; data/sop/eop = FIFO head.
REQ-019 SHALL pop the head exactly on cycles with valid=1 and ready=1; data/sop/eop SHALL hold stable while valid=1 and ready=0.
REQ-020 SHALL give latency 2: with FIFO empty, sample at input on edge N is written at edge N+1 and presented with valid=1 after edge N+1.
REQ-021 SHALL implement states IDLE, CAPTURE, TERMINATE with sample counter cnt (0..FRAME_LEN-1).
REQ-022 IDLE: no writes; capture_enable=1 -> CAPTURE with cnt=0.
REQ-023 CAPTURE: one write per cycle, sop=(cnt==0), eop=(cnt==FRAME_LEN-1), cnt increments.
REQ-024 At eop write: frame_count+1, cnt=0; capture_enable=1 -> stay CAPTURE (back-to-back frames, no gap); else -> IDLE.
REQ-025 capture_enable deassert mid-frame SHALL NOT truncate; frame completes to eop.
REQ-026 FIFO full with simultaneous pop SHALL accept the write (no overflow).
REQ-027 FIFO full without pop in CAPTURE: discard sample, set overflow; cnt!=0 -> TERMINATE; cnt==0 -> IDLE (no orphan eop).
REQ-028 TERMINATE: on first cycle FIFO can accept, write data=0, sop=0, eop=1, -> IDLE; frame_count SHALL NOT increment.
REQ-029 clear_overflow=1 clears overflow next edge; simultaneous new overflow SHALL win (flag stays 1).
REQ-030 Samples arriving in IDLE/TERMINATE SHALL be discarded.

Reset
REQ-031 reset_reset=1 at an edge SHALL: state=IDLE, cnt=0, FIFO empty, overflow=0, frame_count=0, input stage=0.
REQ-032 During/after reset until first write: aso_out0_valid=0, aso_out0_data=0, sop=0, eop=0.
REQ-033 Reset mid-frame SHALL discard the partial frame without emitting eop.

Verification
REQ-034 FRAME_LEN=4, ready=1, enable 1 for 4 cycles, ChA=100..103, ChB=-100..-103 -> 4 words, first sop, last eop, data[5:0]=0, frame_count=1, first valid 2 cycles after first sample.
REQ-035 Enable held, ready=1, FRAME_LEN=4 -> 12 consecutive valid words, sop every 4th, no gap, frame_count=3.
REQ-036 FIFO_DEPTH=4, FRAME_LEN=8, ready=0 -> 4 words stored, overflow=1 at 5th sample, then ready=1 drains 4 words plus terminator (data=0, eop=1), frame_count=0.
REQ-037 ready toggling 1/0 each cycle with FIFO nearly full -> data/sop/eop stable while stalled, no loss, overflow stays 0 when pops balance writes.
REQ-038 reset_reset asserted at sample 2 of a frame -> next cycle valid=0, FIFO empty, counters 0; next capture begins with sop.
REQ-039 clear_overflow and a new overflow on same edge -> overflow remains 1.

Source files
------------

// File: rtl/ofdm_adc_capture.sv
// OFDM ADC frame capture: registers I/Q samples, frames them into packets
// and streams them out through a show-ahead FIFO on an Avalon-ST source.
module ofdm_adc_capture #(
  parameter int FRAME_LEN  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        sample_clock_adc,
  input  logic        reset_reset,
  input  logic        capture_enable,
  input  logic [13:0] ADC_Capture_ChA_Data,
  input  logic [13:0] ADC_Capture_ChB_Data,
  output logic [33:0] aso_out0_data,
  output logic        aso_out0_valid,
  input  logic        aso_out0_ready,
  output logic        aso_out0_startofpacket,
  output logic        aso_out0_endofpacket,
  output logic        overflow,
  input  logic        clear_overflow,
  output logic [15:0] frame_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    TERMINATE
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [13:0] cha_q, chb_q;

  logic [35:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [35:0] head;
  logic empty, full, pop, can_push;

  logic        push;
  logic [35:0] push_word;
  logic        ovf_set;
  logic        frame_inc;

  always_ff @(posedge sample_clock_adc) begin
    if (reset_reset) begin
      cha_q <= '0;
      chb_q <= '0;
    end else begin
      cha_q <= ADC_Capture_ChA_Data;
      chb_q <= ADC_Capture_ChB_Data;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && aso_out0_ready;
  assign can_push = !full || pop;
  assign head     = mem[rd_ptr[AW-1:0]];

  // Head is masked while empty so stale storage never leaks out
  assign aso_out0_valid         = !empty;
  assign aso_out0_data          = empty ? '0 : head[35:2];
  assign aso_out0_startofpacket = !empty && head[1];
  assign aso_out0_endofpacket   = !empty && head[0];

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    push      = 1'b0;
    push_word = '0;
    ovf_set   = 1'b0;
    frame_inc = 1'b0;
    case (state)
      IDLE: begin
        if (capture_enable) begin
          state_n = CAPTURE;
          cnt_n   = '0;
        end
      end
      CAPTURE: begin
        if (can_push) begin
          push      = 1'b1;
          push_word = {cha_q, chb_q, 6'b000000,
                       cnt == '0, cnt == LAST};
          if (cnt == LAST) begin
            frame_inc = 1'b1;
            cnt_n     = '0;
            state_n   = capture_enable ? CAPTURE : IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else begin
          ovf_set = 1'b1;
          cnt_n   = '0;
          // A frame that never started needs no terminator
          state_n = (cnt != '0) ? TERMINATE : IDLE;
        end
      end
      TERMINATE: begin
        if (can_push) begin
          push      = 1'b1;
          push_word = {34'd0, 1'b0, 1'b1};
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sample_clock_adc) begin
    if (reset_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set)             overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
      if (frame_inc) frame_count <= frame_count + 16'd1;
    end
  end

  always_ff @(posedge sample_clock_adc) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_word;
  end

endmodule

// File: tb/tb_ofdm_adc_capture.sv
// Directed self-checking bench for ofdm_adc_capture: short-frame instance
// and a long-frame instance that exercises the overflow terminator.
module tb_ofdm_adc_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [13:0] cha = '0;
  logic [13:0] chb = '0;
  logic        ready = 1'b0;
  logic        clr = 1'b0;

  logic [33:0] a_data, b_data;
  logic        a_valid, a_sop, a_eop, a_ovf;
  logic        b_valid, b_sop, b_eop, b_ovf;
  logic [15:0] a_fc, b_fc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ofdm_adc_capture #(.FRAME_LEN(4), .FIFO_DEPTH(4)) dut_a (
    .sample_clock_adc       (clk),
    .reset_reset            (rst),
    .capture_enable         (en),
    .ADC_Capture_ChA_Data   (cha),
    .ADC_Capture_ChB_Data   (chb),
    .aso_out0_data          (a_data),
    .aso_out0_valid         (a_valid),
    .aso_out0_ready         (ready),
    .aso_out0_startofpacket (a_sop),
    .aso_out0_endofpacket   (a_eop),
    .overflow               (a_ovf),
    .clear_overflow         (clr),
    .frame_count            (a_fc)
  );

  ofdm_adc_capture #(.FRAME_LEN(8), .FIFO_DEPTH(4)) dut_b (
    .sample_clock_adc       (clk),
    .reset_reset            (rst),
    .capture_enable         (en),
    .ADC_Capture_ChA_Data   (cha),
    .ADC_Capture_ChB_Data   (chb),
    .aso_out0_data          (b_data),
    .aso_out0_valid         (b_valid),
    .aso_out0_ready         (ready),
    .aso_out0_startofpacket (b_sop),
    .aso_out0_endofpacket   (b_eop),
    .overflow               (b_ovf),
    .clear_overflow         (clr),
    .frame_count            (b_fc)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got a=%b b=%b want 0", a_valid, b_valid);
    end
    n_checks++;
    if (a_data !== 34'd0 || a_sop !== 1'b0 || a_eop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out got data=%h sop=%b eop=%b want 0",
               a_data, a_sop, a_eop);
    end
    n_checks++;
    if (a_ovf !== 1'b0 || a_fc !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_status got ovf=%b fc=%0d want 0 0", a_ovf, a_fc);
    end
  endtask

  task automatic test_single_frame;
    int w;
    logic [33:0] exp;
    do_reset();
    ready = 1'b1;
    w = 0;
    for (int k = 0; k < 12; k++) begin
      en  = (k < 4);
      cha = 14'(100 + k);
      chb = 14'(-100 - k);
      tick();
      if (a_valid) begin
        exp = {14'(100 + w), 14'(-100 - w), 6'd0};
        n_checks++;
        if (a_data !== exp) begin
          n_fail++;
          $display("FAIL single_data w=%0d got %h want %h", w, a_data, exp);
        end
        n_checks++;
        if (a_sop !== (w == 0) || a_eop !== (w == 3)) begin
          n_fail++;
          $display("FAIL single_flags w=%0d got sop=%b eop=%b", w, a_sop, a_eop);
        end
        n_checks++;
        if (k != w + 1) begin
          n_fail++;
          $display("FAIL single_latency w=%0d got edge %0d want %0d", w, k, w + 1);
        end
        w++;
      end
    end
    n_checks++;
    if (w != 4 || a_fc !== 16'd1) begin
      n_fail++;
      $display("FAIL single_count got words=%0d fc=%0d want 4 1", w, a_fc);
    end
    n_checks++;
    if (b_fc !== 16'd1) begin
      n_fail++;
      $display("FAIL no_truncate got fc=%0d want 1", b_fc);
    end
  endtask

  task automatic test_back_to_back;
    int w;
    logic [33:0] exp;
    do_reset();
    ready = 1'b1;
    w = 0;
    for (int k = 0; k < 16; k++) begin
      en  = (k < 12);
      cha = 14'(k);
      chb = 14'(1000 + k);
      tick();
      if (a_valid) begin
        exp = {14'(w), 14'(1000 + w), 6'd0};
        n_checks++;
        if (a_data !== exp || a_sop !== (w % 4 == 0) || a_eop !== (w % 4 == 3)) begin
          n_fail++;
          $display("FAIL b2b_word w=%0d got %h/%b/%b want %h", w, a_data,
                   a_sop, a_eop, exp);
        end
        n_checks++;
        if (k != w + 1) begin
          n_fail++;
          $display("FAIL b2b_gap w=%0d got edge %0d want %0d", w, k, w + 1);
        end
        w++;
      end
    end
    n_checks++;
    if (w != 12 || a_fc !== 16'd3) begin
      n_fail++;
      $display("FAIL b2b_count got words=%0d fc=%0d want 12 3", w, a_fc);
    end
  endtask

  task automatic test_overflow;
    int w;
    logic [33:0] exp;
    do_reset();
    ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      en  = (k == 0);
      cha = 14'(200 + k);
      chb = 14'(-200 - k);
      tick();
      if (k == 4) begin
        n_checks++;
        if (b_ovf !== 1'b0 || b_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL ovf_full got ovf=%b valid=%b want 0 1", b_ovf, b_valid);
        end
      end
      if (k == 5) begin
        n_checks++;
        if (b_ovf !== 1'b1) begin
          n_fail++;
          $display("FAIL ovf_set got %b want 1", b_ovf);
        end
      end
    end
    ready = 1'b1;
    en    = 1'b0;
    w = 0;
    for (int k = 0; k < 10; k++) begin
      if (b_valid) begin
        exp = (w < 4) ? {14'(200 + w), 14'(-200 - w), 6'd0} : 34'd0;
        n_checks++;
        if (b_data !== exp || b_sop !== (w == 0) || b_eop !== (w == 4)) begin
          n_fail++;
          $display("FAIL ovf_drain w=%0d got %h/%b/%b want %h", w, b_data,
                   b_sop, b_eop, exp);
        end
        w++;
      end
      tick();
    end
    n_checks++;
    if (w != 5 || b_fc !== 16'd0 || b_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_end got words=%0d fc=%0d ovf=%b want 5 0 1",
               w, b_fc, b_ovf);
    end
  endtask

  task automatic test_clear_overflow;
    int w;
    int eops;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (b_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_plain got %b want 0", b_ovf);
    end
    do_reset();
    ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      en  = 1'b1;
      clr = (k == 5);
      cha = 14'(k);
      chb = 14'(k);
      tick();
    end
    en = 1'b0;
    n_checks++;
    if (b_ovf !== 1'b1 || a_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_race got a=%b b=%b want 1 1", a_ovf, b_ovf);
    end
    tick();
    clr = 1'b0;
    n_checks++;
    if (b_ovf !== 1'b0 || a_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_after got a=%b b=%b want 0 0", a_ovf, b_ovf);
    end
    ready = 1'b1;
    w = 0;
    eops = 0;
    for (int k = 0; k < 10; k++) begin
      if (a_valid) begin
        w++;
        if (a_eop) eops++;
      end
      tick();
    end
    n_checks++;
    if (w != 4 || eops != 1) begin
      n_fail++;
      $display("FAIL boundary_ovf got words=%0d eops=%0d want 4 1", w, eops);
    end
  endtask

  task automatic test_stall;
    int w;
    logic held;
    logic [35:0] hold_word;
    logic [33:0] exp;
    do_reset();
    w = 0;
    hold_word = '0;
    for (int k = 0; k < 24; k++) begin
      en    = (k <= 4);
      cha   = 14'(300 + k);
      chb   = 14'(-300 - k);
      ready = (k % 2 == 0);
      held  = 1'b0;
      if (a_valid && ready) begin
        exp = {14'(300 + w), 14'(-300 - w), 6'd0};
        n_checks++;
        if (a_data !== exp || a_sop !== (w % 4 == 0) || a_eop !== (w % 4 == 3)) begin
          n_fail++;
          $display("FAIL stall_word w=%0d got %h/%b/%b want %h", w, a_data,
                   a_sop, a_eop, exp);
        end
        w++;
      end else if (a_valid) begin
        held = 1'b1;
        hold_word = {a_data, a_sop, a_eop};
      end
      tick();
      if (held) begin
        n_checks++;
        if (a_valid !== 1'b1 || {a_data, a_sop, a_eop} !== hold_word) begin
          n_fail++;
          $display("FAIL stall_hold k=%0d got %h want %h", k,
                   {a_data, a_sop, a_eop}, hold_word);
        end
      end
    end
    n_checks++;
    if (w != 8 || a_ovf !== 1'b0 || a_fc !== 16'd2) begin
      n_fail++;
      $display("FAIL stall_end got words=%0d ovf=%b fc=%0d want 8 0 2",
               w, a_ovf, a_fc);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [33:0] exp;
    do_reset();
    ready = 1'b0;
    en  = 1'b1;
    cha = 14'd400;
    chb = 14'd401;
    tick();
    en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (a_valid !== 1'b0 || a_data !== 34'd0 || a_eop !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_out got valid=%b data=%h eop=%b want 0",
               a_valid, a_data, a_eop);
    end
    n_checks++;
    if (a_fc !== 16'd0 || a_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_cnt got fc=%0d ovf=%b want 0 0", a_fc, a_ovf);
    end
    rst   = 1'b0;
    ready = 1'b1;
    en  = 1'b1;
    cha = 14'(500);
    chb = 14'(-500);
    tick();
    en = 1'b0;
    tick();
    exp = {14'(500), 14'(-500), 6'd0};
    n_checks++;
    if (a_valid !== 1'b1 || a_sop !== 1'b1 || a_eop !== 1'b0 || a_data !== exp) begin
      n_fail++;
      $display("FAIL midrst_restart got v=%b sop=%b eop=%b %h want 1 1 0 %h",
               a_valid, a_sop, a_eop, a_data, exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_clear_overflow();
    test_stall();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
